// File: rtl/sec_lock_pipe.sv
// Two-stage SECDED decoder with key-locked syndrome LUTs, valid/ready flow control
// and saturating corrected/uncorrectable beat counters.
module sec_lock_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned P       = 6,
   parameter int unsigned NUM_LUT = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              CK,
   input  logic              rst_n,
   input  logic              key_load,
   input  logic              key_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [P:0]        chk_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              err_corr,
   output logic              err_uncorr,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   localparam int unsigned KEY_W   = 4 * NUM_LUT;
   localparam int unsigned MAX_POS = DATA_W + P;

   // Codeword position of data bit idx: idx-th non-power-of-two position from 3 upward.
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned cnt;
      int unsigned pos;
      cnt = 0;
      pos = 0;
      for (int unsigned q = 3; q <= MAX_POS; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (cnt == idx) pos = q;
            cnt++;
         end
      end
      return pos;
   endfunction

   function automatic logic [DATA_W-1:0] chk_mask(input int unsigned k);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         m[i] = ((data_pos(i) >> k) & 32'd1) != 32'd0;
      end
      return m;
   endfunction

   logic [KEY_W-1:0]  key;
   logic [P-1:0]      a_c;
   logic [P-1:0]      syn_c;
   logic              pe_c;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [P-1:0]      s1_syn;
   logic              s1_pe;

   logic              s1_take_c;
   logic              s2_adv_c;
   logic              deliver_c;
   logic [DATA_W-1:0] fix_c;
   logic [DATA_W-1:0] corr_data_c;
   logic              corr_c;
   logic              uncorr_c;

   // Serial key shift register, MSB first.
   always_ff @(posedge CK) begin
      if (!rst_n) begin
         key <= '0;
      end else if (key_load) begin
         key <= {key[KEY_W-2:0], key_in};
      end
   end

   // Syndrome generation; the low NUM_LUT bits go through the keyed LUTs.
   for (genvar k = 0; k < P; k++) begin : g_syn
      localparam logic [DATA_W-1:0] MASK = chk_mask(k);
      assign a_c[k] = ^(data_in & MASK);
      if (k < NUM_LUT) begin : g_lock
         logic [3:0] nib;
         assign nib      = key[4*k +: 4];
         assign syn_c[k] = nib[{chk_in[k], a_c[k]}];
      end else begin : g_raw
         assign syn_c[k] = a_c[k] ^ chk_in[k];
      end
   end

   assign pe_c = (^data_in) ^ (^chk_in);

   assign deliver_c = out_valid && out_ready;
   assign s2_adv_c  = !out_valid || out_ready;
   assign in_ready  = !key_load && (!s1_valid || s2_adv_c);
   assign s1_take_c = in_valid && in_ready;

   // Stage 1: capture data with its (locked) syndrome and overall parity.
   always_ff @(posedge CK) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_pe    <= 1'b0;
      end else if (s1_take_c) begin
         s1_valid <= 1'b1;
         s1_data  <= data_in;
         s1_syn   <= syn_c;
         s1_pe    <= pe_c;
      end else if (s2_adv_c) begin
         s1_valid <= 1'b0;
      end
   end

   // Single data-bit correction: flip the bit whose position matches the syndrome.
   for (genvar i = 0; i < DATA_W; i++) begin : g_fix
      localparam int unsigned POS = data_pos(i);
      assign fix_c[i] = s1_pe && (s1_syn == P'(POS));
   end

   assign corr_data_c = s1_data ^ fix_c;

   // pe=1 with syndrome inside the codeword is correctable (check, parity or data bit).
   always_comb begin
      corr_c   = 1'b0;
      uncorr_c = 1'b0;
      if (s1_pe) begin
         if (s1_syn <= P'(MAX_POS)) corr_c   = 1'b1;
         else                       uncorr_c = 1'b1;
      end else if (s1_syn != '0) begin
         uncorr_c = 1'b1;
      end
   end

   // Stage 2: output register, held while stalled.
   always_ff @(posedge CK) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_corr   <= 1'b0;
         err_uncorr <= 1'b0;
      end else if (s2_adv_c) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out   <= corr_data_c;
            err_corr   <= corr_c;
            err_uncorr <= uncorr_c;
         end
      end
   end

   // Saturating counters of delivered beats; clear has priority.
   always_ff @(posedge CK) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (clr_cnt) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (deliver_c) begin
         if (err_corr && (corr_cnt != '1)) begin
            corr_cnt <= corr_cnt + CNT_W'(1);
         end
         if (err_uncorr && (uncorr_cnt != '1)) begin
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Directed self-checking bench for sec_lock_pipe with hand-computed expectations.
module tb_sec_lock_pipe;

   logic        CK;
   logic        rst_n;
   logic        key_load;
   logic        key_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [6:0]  chk_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic        err_corr;
   logic        err_uncorr;
   logic        clr_cnt;
   logic [15:0] corr_cnt;
   logic [15:0] uncorr_cnt;

   int vectors;
   int miscompares;

   sec_lock_pipe dut (
      .CK        (CK),
      .rst_n     (rst_n),
      .key_load  (key_load),
      .key_in    (key_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .chk_in    (chk_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .err_corr  (err_corr),
      .err_uncorr(err_uncorr),
      .clr_cnt   (clr_cnt),
      .corr_cnt  (corr_cnt),
      .uncorr_cnt(uncorr_cnt)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Clean SECDED encoder: check bits equal XOR of data-bit positions, plus overall parity.
   function automatic logic [6:0] enc(input logic [31:0] d);
      logic [5:0]  syn;
      int unsigned idx;
      syn = '0;
      idx = 0;
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[idx]) syn = syn ^ 6'(pos);
            idx++;
         end
      end
      return {(^d) ^ (^syn), syn};
   endfunction

   // One isolated beat with out_ready=1: checks 2-cycle latency and result, then drains it.
   task automatic beat(input string tag, input logic [31:0] d, input logic [6:0] c,
                       input logic [31:0] exp_d, input logic exp_c, input logic exp_u);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in   = d;
      chk_in    = c;
      #1;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(1'b1));
      step();
      in_valid = 1'b0;
      step();
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
      chk({tag, ".data"}, 64'(data_out), 64'(exp_d));
      chk({tag, ".flags"}, 64'({err_corr, err_uncorr}), 64'({exp_c, exp_u}));
      step();
   endtask

   logic [7:0]  key_val;
   logic [7:0]  pat;
   logic [31:0] sd [8];
   int          sent;
   int          got;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        acc;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      key_load    = 1'b0;
      key_in      = 1'b0;
      in_valid    = 1'b0;
      data_in     = '0;
      chk_in      = '0;
      out_ready   = 1'b1;
      clr_cnt     = 1'b0;
      step();
      step();
      chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
      chk("rst.data_out", 64'(data_out), 64'(0));
      chk("rst.flags", 64'({err_corr, err_uncorr}), 64'(2'b00));
      chk("rst.counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));
      rst_n = 1'b1;
      step();
      chk("rst.in_ready", 64'(in_ready), 64'(1'b1));

      // Default key 0 forces locked syndrome bits to 0: s=0, pe=1.
      beat("wrongkey", 32'h0000_0001, 7'h00, 32'h0000_0001, 1'b1, 1'b0);
      chk("wrongkey.corr_cnt", 64'(corr_cnt), 64'(1));

      key_val = 8'h66;
      for (int i = 7; i >= 0; i--) begin
         key_load = 1'b1;
         key_in   = key_val[i];
         #1;
         if (i == 7) chk("keyload.in_ready", 64'(in_ready), 64'(1'b0));
         step();
      end
      key_load = 1'b0;

      beat("clean0", 32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0);
      beat("d0flip", 32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
      chk("d0flip.corr_cnt", 64'(corr_cnt), 64'(2));
      beat("double", 32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1);
      chk("double.uncorr_cnt", 64'(uncorr_cnt), 64'(1));
      beat("chkbit", 32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0);
      beat("parbit", 32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0);
      beat("d31flip", 32'h8000_0000, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
      beat("synhigh", 32'h8000_0000, 7'h41, 32'h8000_0000, 1'b0, 1'b1);
      beat("clean1", 32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0);
      chk("enc.d1", 64'(enc(32'h0000_0001)), 64'(7'h43));
      chk("cnt.before_stream", 64'({corr_cnt, uncorr_cnt}), 64'({16'd5, 16'd2}));

      // Stream 8 clean beats under out_ready pattern 1,0,0,1,0,1,1,1.
      pat = 8'hE9;
      for (int i = 0; i < 8; i++) sd[i] = 32'h1234_5678 ^ (32'(i) * 32'h0F0F_1111);
      sent       = 0;
      got        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
         in_valid  = (sent < 8);
         data_in   = (sent < 8) ? sd[sent] : 32'h0;
         chk_in    = enc(data_in);
         #1;
         acc = in_valid && in_ready;
         if ((sent - got) == 2 && !out_ready) begin
            chk("stream.full_in_ready", 64'(in_ready), 64'(1'b0));
         end
         if (out_valid && prev_stall) begin
            chk("stream.stall_hold", 64'(data_out), 64'(prev_data));
         end
         if (out_valid && out_ready) begin
            chk($sformatf("stream.beat%0d", got), 64'({err_corr, err_uncorr, data_out}),
                64'({2'b00, sd[got]}));
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = data_out;
         if (acc) sent++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream.delivered", 64'(got), 64'(8));

      // Reset with two beats in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = 32'h0000_0001;
      chk_in    = 7'h00;
      step();
      step();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      chk("midrst.out_valid", 64'(out_valid), 64'(1'b0));
      chk("midrst.counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      chk("midrst.no_ghost", 64'(out_valid), 64'(1'b0));
      beat("midrst.key0", 32'h0000_0001, 7'h00, 32'h0000_0001, 1'b1, 1'b0);

      // Saturation: stream corrected beats until the counter pegs.
      in_valid = 1'b1;
      data_in  = 32'h0000_0001;
      chk_in   = 7'h00;
      for (int n = 0; n < 70000 && corr_cnt != 16'hFFFF; n++) step();
      chk("sat.reached", 64'(corr_cnt), 64'(16'hFFFF));
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("sat.hold", 64'(corr_cnt), 64'(16'hFFFF));

      // Clear coinciding with a counted delivery.
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("clr.pending", 64'({out_valid, err_corr}), 64'(2'b11));
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("clr.wins", 64'(corr_cnt), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sec_lock_pipe.md
Name: sec_lock_pipe

Overview:
- Parametrised, pipelined successor to the combinational 32-bit single-error-correcting block.
- Decodes a DATA_W-bit word protected by an extended-Hamming (SECDED) check field and returns the corrected word with error flags.
- NUM_LUT syndrome bits pass through key-programmable 4-entry LUTs. The key is loaded serially at run time.
- Sits between an upstream valid/ready source and a downstream sink. Also keeps saturating error counters.

Parameters:
- DATA_W, 32, data word width (≥4).
- P, 6, Hamming check bits; must equal the smallest p with 2^p ≥ DATA_W+p+1.
- NUM_LUT, 2, number of locked syndrome bits (1..P); these are syndrome bits 0..NUM_LUT-1.
- CNT_W, 16, width of each error counter.

Ports:
- CK  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  key shift enable
- key_in  in  1  serial key bit, MSB first
- in_valid  in  1  input beat valid
- in_ready  out  1  input accepted when in_valid&in_ready
- data_in  in  DATA_W  received data
- chk_in  in  P+1  received check bits [P-1:0] plus overall parity at [P]
- out_valid  out  1  output beat valid
- out_ready  in  1  sink ready
- data_out  out  DATA_W  corrected data
- err_corr  out  1  single error corrected (includes a check-bit error)
- err_uncorr  out  1  uncorrectable error detected
- clr_cnt  in  1  synchronous counter clear
- corr_cnt  out  CNT_W  count of err_corr beats delivered
- uncorr_cnt  out  CNT_W  count of err_uncorr beats delivered

Behaviour:
- Reset (rst_n=0 at edge): key=0, both stage valids=0, out_valid=0, data_out=0, err_corr=0, err_uncorr=0, counters=0. Reset mid-operation discards all in-flight beats.
- Key register (4*NUM_LUT bits): when key_load=1, key <= {key[4*NUM_LUT-2:0], key_in}. LUT j uses key[4j+3:4j]. in_ready=0 in any cycle with key_load=1. Beats already past stage 1 are unaffected by the new key.
- Codeword mapping:
  - Positions start at 1; positions 2^k hold check bit k.
  - Data bit i occupies the i-th non-power-of-two position in ascending order: bit0→3, bit1→5, bit2→6, bit3→7, bit4→9, …
  - a_k = XOR of data bits whose position has bit k set.
  - Raw syndrome bit k = a_k XOR chk_in[k].
- Locking: for k<NUM_LUT, s_k = key[4k + {chk_in[k], a_k}]; for other k, s_k = raw. The correct key nibble is 4'b0110 per LUT.
- Overall parity: pe = XOR(data_in, chk_in).
- Classification:
  - s=0, pe=0 → clean.
  - pe=1, s=0 → overall parity bit error: err_corr=1, data unchanged.
  - pe=1, s is a power of two → check-bit error: err_corr=1, data unchanged.
  - pe=1, s is a data position ≤ DATA_W+P → flip that data bit, err_corr=1.
  - pe=1, s > DATA_W+P → err_uncorr=1, data unchanged.
  - pe=0, s≠0 → err_uncorr=1, data unchanged.
  - err_corr and err_uncorr are never both 1.
- Pipeline: 2 stages.
  - Stage 1 registers data, s, pe.
  - Stage 2 registers data_out and flags.
  - Latency: accepted beat appears on out_valid exactly 2 cycles later if out_ready stays 1.
  - Full throughput is 1 beat/cycle.
- Handshake:
  - A stage advances when the next stage is empty or is draining.
  - in_ready = !key_load && (stage1 empty || stage1 advancing).
  - Output holds stable (data, flags) while out_valid=1 and out_ready=0.
  - No beat is lost or duplicated under arbitrary out_ready toggling.
- Counters:
  - Increment on out_valid&out_ready when the matching flag is set.
  - Saturate at 2^CNT_W-1.
  - clr_cnt wins over a simultaneous increment (result 0).

Test Plan:
- Load key 0x66 (8 key_load cycles, MSB first); data_in=0, chk_in=0 → 2 cycles later data_out=0, err_corr=0, err_uncorr=0.
- Key 0x66, data_in=0x00000001, chk_in=0 → data_out=0, err_corr=1, corr_cnt increments to 1.
- Key 0x66, data_in=0x00000003, chk_in=0 (s=6, pe=0) → data_out=0x00000003, err_uncorr=1, uncorr_cnt=1.
- Key 0x00 (reset default), data_in=0x00000001, chk_in=0 → s forced to 0, pe=1 → data_out=0x00000001, err_corr=1 (wrong-key corruption visible).
- Stream 8 beats while out_ready = 1,0,0,1,0,1,1,1 → all 8 delivered in order, data stable during stalls, in_ready=0 when both stages are full and stalled.
- Pulse rst_n=0 with 2 beats in flight → out_valid=0 the next cycle, counters=0, key=0. Drive corr_cnt to 0xFFFF, send another corrected beat → stays 0xFFFF.
